// File: rtl/ram_io_responder.sv
// Responder for the CPU byte-wide memory bus: 128 KB on-chip RAM plus an I/O window
// at a[17:16]==2'b11 with UART RX/TX ports, a free-running cycle counter and a stop port.
module ram_io_responder #(
  parameter int unsigned ADDR_W          = 17,
  parameter int unsigned TX_DEPTH        = 16,
  parameter int unsigned TX_AFULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted,
  output logic        tx_overflow
);

  localparam int unsigned PtrW = $clog2(TX_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [17:0] AddrRx  = 18'h30000;
  localparam logic [17:0] AddrCnt = 18'h30004;

  // Storage (not reset)
  logic [7:0] ram_q    [2**ADDR_W];
  logic [7:0] tx_mem_q [TX_DEPTH];

  // Registered state
  logic [7:0]      din_q,      din_d;
  logic [31:0]     cnt_q,      cnt_d;
  logic [31:0]     snap_q,     snap_d;
  logic [PtrW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CntW-1:0] count_q,    count_d;
  logic            halted_q,   halted_d;
  logic            overflow_q, overflow_d;
  logic            afull_q,    afull_d;

  // Decode
  logic [17:0] a_low;
  logic        sel_ram, sel_io;
  logic        io_rx, io_cnt0, io_cnt_any;
  logic        unused_a_hi;

  assign a_low       = cpu_a[17:0];
  assign unused_a_hi = ^cpu_a[31:18];
  assign sel_ram     = ~a_low[17];
  assign sel_io      = (a_low[17:16] == 2'b11);
  assign io_rx       = (a_low == AddrRx);
  assign io_cnt0     = (a_low == AddrCnt);
  assign io_cnt_any  = (a_low[17:2] == AddrCnt[17:2]);

  // Write-side control
  logic       ram_we;
  logic       io_wr_ok;
  logic       halt_wr;
  logic       push;
  logic       push_ok;
  logic       pop;
  logic       fifo_full;
  logic [7:0] push_byte;

  assign ram_we    = cpu_wr & sel_ram;
  assign io_wr_ok  = cpu_wr & sel_io & ~halted_q;
  assign halt_wr   = io_wr_ok & io_cnt0;
  assign push      = (io_wr_ok & io_rx & (cpu_dout != 8'h00)) | halt_wr;
  assign push_byte = halt_wr ? 8'h00 : cpu_dout;

  assign tx_valid  = (count_q != '0);
  assign fifo_full = (count_q == CntW'(TX_DEPTH));
  assign pop       = tx_valid & tx_ready;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok   = push & (~fifo_full | pop);

  // RX consumption happens in the request cycle; held off while in reset.
  assign rx_pop = rst_in & ~cpu_wr & io_rx & rx_valid;

  // Read path and counter snapshot
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    snap_d  = snap_q;
    if (!cpu_wr) begin
      if (sel_ram) begin
        rd_data = ram_q[cpu_a[ADDR_W-1:0]];
      end else if (io_rx) begin
        rd_data = rx_valid ? rx_data : 8'h00;
      end else if (io_cnt0) begin
        rd_data = cnt_q[7:0];
        snap_d  = cnt_q;
      end else if (io_cnt_any) begin
        unique case (a_low[1:0])
          2'd1:    rd_data = snap_q[15:8];
          2'd2:    rd_data = snap_q[23:16];
          default: rd_data = snap_q[31:24];
        endcase
      end
    end
    din_d = cpu_wr ? din_q : rd_data;
  end

  // Next-state for counter, FIFO bookkeeping and sticky flags
  always_comb begin
    cnt_d      = cnt_q + 32'd1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    halted_d   = halted_q | halt_wr;
    overflow_d = overflow_q | (push & ~push_ok);

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Margin covers the CPU seeing the flag one cycle late.
    afull_d = ((CntW'(TX_DEPTH) - count_d) <= CntW'(TX_AFULL_MARGIN));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      din_q      <= 8'h00;
      cnt_q      <= 32'd0;
      snap_q     <= 32'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      afull_q    <= 1'b0;
    end else begin
      din_q      <= din_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
      overflow_q <= overflow_d;
      afull_q    <= afull_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      ram_q[cpu_a[ADDR_W-1:0]] <= cpu_dout;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      tx_mem_q[wr_ptr_q] <= push_byte;
    end
  end

  assign cpu_din        = din_q;
  assign io_buffer_full = afull_q;
  assign halted         = halted_q;
  assign tx_overflow    = overflow_q;
  assign tx_data        = tx_valid ? tx_mem_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: inputs change on the falling edge, outputs are
// checked on the falling edge (or 1 ns after driving, for the combinational rx_pop).
module tb_ram_io_responder;

  localparam logic [31:0] Idle = 32'h0002_0000;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_pop;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halted;
  logic        tx_overflow;

  int checks = 0;
  int errors = 0;

  ram_io_responder #(
    .ADDR_W         (17),
    .TX_DEPTH       (16),
    .TX_AFULL_MARGIN(2)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .cpu_a         (cpu_a),
    .cpu_wr        (cpu_wr),
    .cpu_dout      (cpu_dout),
    .cpu_din       (cpu_din),
    .io_buffer_full(io_buffer_full),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_pop        (rx_pop),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .halted        (halted),
    .tx_overflow   (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one bus access and advance to the next falling edge.
  task automatic cycle(input logic [31:0] a, input logic wr, input logic [7:0] d);
    cpu_a    = a;
    cpu_wr   = wr;
    cpu_dout = d;
    @(negedge clk_in);
  endtask

  initial begin
    logic [7:0] b0, b1, b2, b3;

    rst_in   = 1'b0;
    cpu_a    = Idle;
    cpu_wr   = 1'b0;
    cpu_dout = 8'h00;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk_in);

    chk("rst_cpu_din", cpu_din, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_tx_overflow", tx_overflow, 1'b0);
    chk("rst_io_buffer_full", io_buffer_full, 1'b0);
    cpu_a    = 32'h0003_0000;
    rx_valid = 1'b1;
    #1 chk("rst_rx_pop_gated", rx_pop, 1'b0);
    cpu_a    = Idle;
    rx_valid = 1'b0;
    @(negedge clk_in);

    // Counter: 100 rising edges after release, then read the snapshot bytes.
    rst_in = 1'b1;
    repeat (100) @(negedge clk_in);
    cycle(32'h0003_0004, 1'b0, 8'h00); b0 = cpu_din;
    cycle(32'h0003_0005, 1'b0, 8'h00); b1 = cpu_din;
    cycle(32'h0003_0006, 1'b0, 8'h00); b2 = cpu_din;
    cycle(32'h0003_0007, 1'b0, 8'h00); b3 = cpu_din;
    chk("cnt_byte0", b0, 8'd100);
    chk("cnt_snapshot", {b3, b2, b1, b0}, 32'd100);
    cycle(32'h0003_0008, 1'b0, 8'h00);
    chk("io_unmapped_read", cpu_din, 8'h00);

    // RAM and hole
    cycle(32'h0000_0010, 1'b1, 8'h5A);
    cycle(32'h0000_0010, 1'b0, 8'h00);
    chk("ram_raw", cpu_din, 8'h5A);
    cycle(32'h0000_0011, 1'b1, 8'h99);
    chk("din_hold_on_write", cpu_din, 8'h5A);
    cycle(32'h0000_0011, 1'b0, 8'h00);
    chk("ram_read_0x11", cpu_din, 8'h99);
    cycle(32'hFFFC_0010, 1'b0, 8'h00);
    chk("ram_high_bits_ignored", cpu_din, 8'h5A);
    cycle(32'h0002_5000, 1'b1, 8'h77);
    cycle(32'h0002_5000, 1'b0, 8'h00);
    chk("hole_read", cpu_din, 8'h00);

    // UART RX
    rx_valid = 1'b1;
    rx_data  = 8'h7E;
    cpu_a    = 32'h0003_0000;
    cpu_wr   = 1'b0;
    #1 chk("rx_pop_pulse", rx_pop, 1'b1);
    @(negedge clk_in);
    chk("rx_read_data", cpu_din, 8'h7E);
    cpu_a = Idle;
    #1 chk("rx_pop_idle", rx_pop, 1'b0);
    @(negedge clk_in);
    rx_valid = 1'b0;
    cpu_a    = 32'h0003_0000;
    #1 chk("rx_no_pop_empty", rx_pop, 1'b0);
    @(negedge clk_in);
    chk("rx_read_empty", cpu_din, 8'h00);

    // UART TX with a ready sink; 0x00 writes are skipped.
    tx_ready = 1'b1;
    cycle(32'h0003_0000, 1'b1, 8'h41);
    chk("tx1_valid", tx_valid, 1'b1);
    chk("tx1_data", tx_data, 8'h41);
    cycle(32'h0003_0000, 1'b1, 8'h00);
    chk("tx_zero_skipped", tx_valid, 1'b0);
    cycle(32'h0003_0000, 1'b1, 8'h42);
    chk("tx2_valid", tx_valid, 1'b1);
    chk("tx2_data", tx_data, 8'h42);
    cycle(Idle, 1'b0, 8'h00);
    chk("tx_drained", tx_valid, 1'b0);

    // Fill the FIFO with a stalled sink, overflow it, then drain.
    tx_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cycle(32'h0003_0000, 1'b1, 8'(i));
      if (i == 13) chk("afull_after_13", io_buffer_full, 1'b0);
      if (i == 14) chk("afull_after_14", io_buffer_full, 1'b1);
    end
    chk("no_overflow_at_16", tx_overflow, 1'b0);
    cycle(32'h0003_0000, 1'b1, 8'hEE);
    chk("overflow_set", tx_overflow, 1'b1);
    cycle(Idle, 1'b0, 8'h00);
    tx_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain_valid_%0d", i), tx_valid, 1'b1);
      chk($sformatf("drain_data_%0d", i), tx_data, 8'(i));
      cycle(Idle, 1'b0, 8'h00);
    end
    chk("drain_empty", tx_valid, 1'b0);
    chk("afull_cleared", io_buffer_full, 1'b0);
    chk("overflow_sticky", tx_overflow, 1'b1);

    // Halt: 12 bytes queued, stop write adds 0x00 (count 13), later IO writes ignored.
    tx_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(32'h0003_0000, 1'b1, 8'(8'h51 + i));
    end
    cycle(32'h0003_0004, 1'b1, 8'hFF);
    chk("halted_set", halted, 1'b1);
    chk("halt_count13_afull", io_buffer_full, 1'b0);
    cycle(32'h0003_0000, 1'b1, 8'h43);
    chk("halted_write_ignored", io_buffer_full, 1'b0);
    cycle(32'h0000_0020, 1'b1, 8'h33);
    cycle(32'h0000_0020, 1'b0, 8'h00);
    chk("ram_while_halted", cpu_din, 8'h33);
    tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("halt_drain_%0d", i), tx_data, 8'(8'h51 + i));
      cycle(32'h0000_0010, 1'b0, 8'h00);
    end
    chk("stop_byte_valid", tx_valid, 1'b1);
    chk("stop_byte_data", tx_data, 8'h00);
    chk("din_before_reset", cpu_din, 8'h5A);

    // Reset mid-drain with a read in flight.
    rst_in = 1'b0;
    #1;
    chk("midrst_tx_valid", tx_valid, 1'b0);
    chk("midrst_halted", halted, 1'b0);
    chk("midrst_cpu_din", cpu_din, 8'h00);
    chk("midrst_tx_overflow", tx_overflow, 1'b0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in   = 1'b1;
    tx_ready = 1'b0;
    cycle(32'h0000_0010, 1'b0, 8'h00);
    chk("ram_survives_reset", cpu_din, 8'h5A);
    cycle(32'h0003_0000, 1'b1, 8'h44);
    chk("io_write_after_reset", tx_data, 8'h44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
